// File: rtl/sqg_pkg.sv
// Shared constants and state type for the 0110-marker serial link.
// Imported by the transmitter (sqg0110_tx) and by the matching receiver.
package sqg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PAR,
        GAP
    } tx_state_t;

    localparam logic [3:0] SYNC_PATTERN  = 4'b0110;
    localparam int         SYNC_LEN      = 4;

    // Last three line bits that, followed by a 0, would recreate the marker.
    localparam logic [2:0] STUFF_TRIGGER = 3'b011;

endpackage

// File: rtl/sqg0110_tx.sv
// sqg0110_tx: serial frame transmitter for the 0110-marker link.
// Accepts a W-bit word over valid/ready, sends marker 0110 then the payload
// MSB first, stuffing a 1 whenever the last three line bits are 011 and
// more payload follows, then idles high for GAP_BITS cycles.
// Optional build macro SQG0110_PARITY_EN appends an even-parity bit
// (itself subject to the stuffing rule) after the payload.
module sqg0110_tx
    import sqg_pkg::*;
#(
    parameter int W        = 8,
    parameter int GAP_BITS = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_i,
    input  logic         valid_i,
    output logic         ready_o,
    output logic         out,
    output logic         tx_en,
    output logic         busy_o
);

    // One counter serves every state: marker bits, payload bits, parity
    // progress and gap cycles, so it is sized for the largest of them.
    localparam int CNT_TOP_A = (W > GAP_BITS) ? W : GAP_BITS;
    localparam int CNT_TOP   = (CNT_TOP_A > SYNC_LEN) ? CNT_TOP_A : SYNC_LEN;
    localparam int CW        = $clog2(CNT_TOP + 1);

    tx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic            out_q,   out_d;
    logic            tx_en_q, tx_en_d;
    logic [2:0]      history, history_d;
    logic [1:0]      sync_idx;
`ifdef SQG0110_PARITY_EN
    logic            par_q,   par_d;
`endif

    // Marker bit to send next: cnt_q marker bits are already out, MSB first.
    assign sync_idx = 2'(SYNC_LEN - 1 - int'(cnt_q));

    // State register; out/tx_en are registered so the line never glitches.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of code order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GAP;
            cnt_q   <= '0;
            // NOTE: the payload shifter is reset only for deterministic
            // simulation; it is always reloaded before it is used.
            shreg_q <= '0;
            out_q   <= 1'b1;
            tx_en_q <= 1'b0;
            history <= 3'b111;
`ifdef SQG0110_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            tx_en_q <= tx_en_d;
            history <= history_d;
`ifdef SQG0110_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next state plus the bit to put on the line during the next cycle.
    // state_q always names the phase of the bit currently on out.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a variable unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        out_d   = 1'b1;
        tx_en_d = 1'b0;
`ifdef SQG0110_PARITY_EN
        par_d   = par_q;
`endif

        unique case (state_q)
            IDLE: begin
                // ready_o is high exactly in IDLE, so valid_i is the handshake.
                if (valid_i) begin
                    state_d = SYNC;
                    cnt_d   = CW'(1);
                    shreg_d = data_i;
                    out_d   = SYNC_PATTERN[SYNC_LEN-1];
                    tx_en_d = 1'b1;
`ifdef SQG0110_PARITY_EN
                    par_d   = ^data_i;
`endif
                end
            end

            SYNC: begin
                tx_en_d = 1'b1;
                if (cnt_q != CW'(SYNC_LEN)) begin
                    out_d = SYNC_PATTERN[sync_idx];
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    // The marker leaves history at 110, so the first payload
                    // bit can never need a stuff in front of it.
                    state_d = DATA;
                    out_d   = shreg_q[W-1];
                    shreg_d = shreg_q << 1;
                    cnt_d   = CW'(1);
                end
            end

            DATA: begin
                if (cnt_q != CW'(W)) begin
                    tx_en_d = 1'b1;
                    if (history == STUFF_TRIGGER) begin
                        out_d = 1'b1;
                    end else begin
                        out_d   = shreg_q[W-1];
                        shreg_d = shreg_q << 1;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else begin
`ifdef SQG0110_PARITY_EN
                    // cnt 0 in PAR means a stuff went out and parity is due.
                    state_d = PAR;
                    tx_en_d = 1'b1;
                    if (history == STUFF_TRIGGER) begin
                        out_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        out_d = par_q;
                        cnt_d = CW'(1);
                    end
`else
                    state_d = GAP;
                    cnt_d   = '0;
`endif
                end
            end

            PAR: begin
`ifdef SQG0110_PARITY_EN
                if (cnt_q == '0) begin
                    tx_en_d = 1'b1;
                    out_d   = par_q;
                    cnt_d   = CW'(1);
                end else begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
`else
                state_d = GAP;
                cnt_d   = '0;
`endif
            end

            GAP: begin
                if (cnt_q == CW'(GAP_BITS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = GAP;
                cnt_d   = '0;
            end
        endcase

        history_d = {history[1:0], out_d};
    end

    assign out     = out_q;
    assign tx_en   = tx_en_q;
    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_sqg0110_tx.sv
// Self-checking bench for sqg0110_tx (W=8, GAP_BITS=3).
// A frame-level model predicts out/tx_en/busy_o/ready_o every cycle; literal
// frames pin both the model and the captured line bits.
// Honours SQG0110_PARITY_EN when the design is built with it.
module tb_sqg0110_tx;

    localparam int W        = 8;
    localparam int GAP_BITS = 3;
    localparam logic [3:0] MARKER = 4'b0110;

    logic         clk;
    logic         rst;
    logic [W-1:0] data_i;
    logic         valid_i;
    logic         ready_o;
    logic         out;
    logic         tx_en;
    logic         busy_o;

    int total = 0;
    int bad   = 0;

    sqg0110_tx #(.W(W), .GAP_BITS(GAP_BITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .out     (out),
        .tx_en   (tx_en),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Line bits of one frame, MSB-first packed into v, built straight from
    // the framing rules: marker, payload with stuffing, optional parity.
    function automatic logic [63:0] frame_bits(input logic [W-1:0] d, output int len);
        logic [63:0] v;
        v   = '0;
        len = 0;
        for (int i = 3; i >= 0; i--) begin
            v = {v[62:0], MARKER[i]};
            len++;
        end
        for (int i = W - 1; i >= 0; i--) begin
            if (v[2:0] == 3'b011) begin
                v = {v[62:0], 1'b1};
                len++;
            end
            v = {v[62:0], d[i]};
            len++;
        end
`ifdef SQG0110_PARITY_EN
        if (v[2:0] == 3'b011) begin
            v = {v[62:0], 1'b1};
            len++;
        end
        v = {v[62:0], ^d};
        len++;
`endif
        return v;
    endfunction

    typedef struct packed {
        logic o;
        logic te;
        logic bz;
        logic mk;   // last marker bit: a detector must fire on this cycle
    } ent_t;

    localparam ent_t IDLE_E = '{o: 1'b1, te: 1'b0, bz: 1'b0, mk: 1'b0};
    localparam ent_t GAP_E  = '{o: 1'b1, te: 1'b0, bz: 1'b1, mk: 1'b0};

    ent_t cur = GAP_E;
    ent_t q[$];

    task automatic push_frame(input logic [W-1:0] d);
        int len;
        logic [63:0] v;
        v = frame_bits(d, len);
        for (int k = 0; k < len; k++)
            q.push_back('{o: v[len-1-k], te: 1'b1, bz: 1'b1, mk: (k == 3)});
        for (int k = 0; k < GAP_BITS; k++)
            q.push_back(GAP_E);
    endtask

    // Model advance at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                cur = GAP_E;
                q.delete();
                for (int i = 0; i < GAP_BITS - 1; i++) q.push_back(GAP_E);
            end else begin
                if (!cur.bz && valid_i) push_frame(data_i);
                cur = (q.size() != 0) ? q.pop_front() : IDLE_E;
            end
        end
    end

    // ---------------- compare / observe ----------------
    int   hits      = 0;
    int   exp_hits  = 0;
    int   idle_run  = 100;
    int   last_gap  = 0;
    logic [3:0] win = 4'b1111;
    logic cap_q[$];

    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            e = rst ? GAP_E : cur;
            check("out",   out,     e.o);
            check("tx_en", tx_en,   e.te);
            check("busy",  busy_o,  e.bz);
            check("ready", ready_o, !e.bz);
            if (!rst && cur.mk) exp_hits++;
            win = {win[2:0], out};
            if (win == 4'b0110) hits++;
            if (tx_en) begin
                cap_q.push_back(out);
                if (idle_run != 0) last_gap = idle_run;
                idle_run = 0;
            end else begin
                idle_run++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready_o && n < 200) begin
            step();
            n++;
        end
        check(name, ready_o, 1'b1);
    endtask

    task automatic cycles_to_ready(output int n);
        n = 0;
        while (!ready_o && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic check_frame(input string name, input int start,
                               input logic [63:0] lit, input int lit_len);
        logic [63:0] v = '0;
        int n = cap_q.size() - start;
        check({name, "_len"}, n, lit_len);
        for (int i = start; i < cap_q.size(); i++) v = {v[62:0], cap_q[i]};
        check(name, v, lit);
    endtask

    task automatic send(input logic [W-1:0] d);
        wait_ready("ready_before_send");
        valid_i = 1'b1;
        data_i  = d;
        step();
        valid_i = 1'b0;
        data_i  = $urandom;
        wait_ready("ready_after_send");
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic [63:0]  bits;
        int           len;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n, start, h0, e0, mlen;
        logic [63:0] mv;

`ifdef SQG0110_PARITY_EN
        vecs[0] = '{8'h00, 64'b0110000000000,   13};
        vecs[1] = '{8'hB6, 64'b011010111011101, 15};
        vecs[2] = '{8'hC0, 64'b01101110000000,  14};
        vecs[3] = '{8'h07, 64'b01100000011111,  14};
        vecs[4] = '{8'h03, 64'b01100000001110,  14};
`else
        vecs[0] = '{8'h00, 64'b011000000000,    12};
        vecs[1] = '{8'hB6, 64'b01101011101110,  14};
        vecs[2] = '{8'hC0, 64'b0110111000000,   13};
        vecs[3] = '{8'h07, 64'b0110000001111,   13};
        vecs[4] = '{8'h03, 64'b011000000011,    12};
`endif

        // Pin the model against hand-derived frames.
        foreach (vecs[i]) begin
            mv = frame_bits(vecs[i].d, mlen);
            check("model_len",  mlen, vecs[i].len);
            check("model_bits", mv,   vecs[i].bits);
        end

        // Reset and release.
        rst     = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        repeat (3) step();
        check("rst_out",   out,     1'b1);
        check("rst_tx_en", tx_en,   1'b0);
        check("rst_ready", ready_o, 1'b0);
        check("rst_busy",  busy_o,  1'b1);
        rst = 1'b0;
        cycles_to_ready(n);
        check("ready_delay_after_reset", n, GAP_BITS);
        check("busy_when_idle", busy_o, 1'b0);

        // Directed frames with literal line contents.
        foreach (vecs[i]) begin
            h0    = hits;
            start = cap_q.size();
            send(vecs[i].d);
            check_frame("frame_bits", start, vecs[i].bits, vecs[i].len);
            check("frame_hits", hits - h0, 1);
        end

        // Back-to-back with valid_i held high.
        wait_ready("ready_before_b2b");
        h0      = hits;
        valid_i = 1'b1;
        data_i  = 8'hB6;
        step();
        data_i  = 8'h00;
        wait_ready("ready_mid_b2b");
        step();
        valid_i = 1'b0;
        wait_ready("ready_after_b2b");
        check("b2b_gap", last_gap, GAP_BITS + 1);
        check("b2b_hits", hits - h0, 2);

        // Reset in the middle of a 0xFF payload.
        h0      = hits;
        valid_i = 1'b1;
        data_i  = 8'hFF;
        step();
        valid_i = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        #1;
        check("midrst_out",   out,     1'b1);
        check("midrst_tx_en", tx_en,   1'b0);
        check("midrst_ready", ready_o, 1'b0);
        repeat (2) step();
        rst = 1'b0;
        cycles_to_ready(n);
        check("ready_delay_after_midrst", n, GAP_BITS);
        repeat (8) step();
        check("midrst_hits", hits - h0, 1);

        // Randomised traffic with valid drops and rare resets.
        e0 = exp_hits;
        h0 = hits;
        for (int c = 0; c < 1500; c++) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            valid_i = ($urandom_range(0, 2) != 0);
            data_i  = $urandom;
            step();
        end
        rst     = 1'b0;
        valid_i = 1'b0;
        wait_ready("ready_after_random");
        repeat (4) step();
        check("random_hits", hits - h0, exp_hits - e0);
        check("total_hits",  hits, exp_hits);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
